cpu_run_ctrl: RTL and testbench

Run controller that sequences the MIDS CPU core through complete program executions. It holds the CPU in reset after power-up, selects a program, issues the Start pulse and waits for Ack. It measures the run length in cycles and recovers the CPU with a watchdog reset if Ack never arrives. It sits between the host/bench request interface and the CPU's Reset/Start/Ack pins.

---
 rtl/cpu_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the MIDS CPU: reset hold, program launch, Ack wait,
// run-length measurement and watchdog recovery.
module cpu_run_ctrl #(
    parameter int unsigned PROG_W     = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic [PROG_W-1:0] ProgSel,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic              TimedOut,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              CpuReset,
    output logic              CpuStart,
    output logic [PROG_W-1:0] CpuProgSel,
    input  logic              CpuAck
);

    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W:0]    WD_LIMIT  = (CNT_W+1)'(TIMEOUT);

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        LAUNCH   = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0]    run_cnt, run_cnt_nxt;
    logic                armed, armed_nxt;
    logic                busy, busy_nxt;
    logic                done, done_nxt;
    logic                timed_out, timed_out_nxt;
    logic [CNT_W-1:0]    cycle_count, cycle_count_nxt;
    logic                cpu_reset, cpu_reset_nxt;
    logic                cpu_start, cpu_start_nxt;
    logic [PROG_W-1:0]   cpu_prog_sel, cpu_prog_sel_nxt;

    logic [CNT_W-1:0]    run_sat;
    logic                wd_hit;
    logic                ack_ok;

    assign run_sat = (&run_cnt) ? run_cnt : run_cnt + CNT_W'(1);
    assign wd_hit  = ({1'b0, run_cnt} + (CNT_W+1)'(1)) == WD_LIMIT;
    // An Ack counts only after it has been seen low in this run.
    assign ack_ok  = CpuAck && armed;

    // Next-state and next-output logic
    always_comb begin
        state_nxt        = state;
        hold_cnt_nxt     = hold_cnt;
        run_cnt_nxt      = run_cnt;
        armed_nxt        = armed;
        busy_nxt         = busy;
        done_nxt         = done;
        timed_out_nxt    = timed_out;
        cycle_count_nxt  = cycle_count;
        cpu_reset_nxt    = cpu_reset;
        cpu_start_nxt    = 1'b0;
        cpu_prog_sel_nxt = cpu_prog_sel;

        case (state)
            RST_HOLD: begin
                cpu_reset_nxt = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt     = IDLE;
                    cpu_reset_nxt = 1'b0;
                    hold_cnt_nxt  = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            IDLE, DONE: begin
                if (Req) begin
                    state_nxt        = LAUNCH;
                    cpu_prog_sel_nxt = ProgSel;
                    timed_out_nxt    = 1'b0;
                    done_nxt         = 1'b0;
                    busy_nxt         = 1'b1;
                    cpu_start_nxt    = 1'b1;
                end
            end
            LAUNCH: begin
                state_nxt   = RUN;
                run_cnt_nxt = '0;
                armed_nxt   = 1'b0;
            end
            RUN: begin
                run_cnt_nxt = run_sat;
                if (!CpuAck) begin
                    armed_nxt = 1'b1;
                end
                if (Abort || (!ack_ok && wd_hit)) begin
                    state_nxt     = RST_HOLD;
                    hold_cnt_nxt  = '0;
                    cpu_reset_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    done_nxt      = 1'b0;
                    if (!Abort) begin
                        timed_out_nxt = 1'b1;
                    end
                end else if (ack_ok) begin
                    state_nxt       = DONE;
                    cycle_count_nxt = run_sat;
                    done_nxt        = 1'b1;
                    busy_nxt        = 1'b0;
                end
            end
            default: begin
                state_nxt     = RST_HOLD;
                hold_cnt_nxt  = '0;
                cpu_reset_nxt = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= RST_HOLD;
            hold_cnt     <= '0;
            run_cnt      <= '0;
            armed        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            cycle_count  <= '0;
            cpu_reset    <= 1'b1;
            cpu_start    <= 1'b0;
            cpu_prog_sel <= '0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            run_cnt      <= run_cnt_nxt;
            armed        <= armed_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            timed_out    <= timed_out_nxt;
            cycle_count  <= cycle_count_nxt;
            cpu_reset    <= cpu_reset_nxt;
            cpu_start    <= cpu_start_nxt;
            cpu_prog_sel <= cpu_prog_sel_nxt;
        end
    end

    assign Busy       = busy;
    assign Done       = done;
    assign TimedOut   = timed_out;
    assign CycleCount = cycle_count;
    assign CpuReset   = cpu_reset;
    assign CpuStart   = cpu_start;
    assign CpuProgSel = cpu_prog_sel;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: directed runs queue expected events,
// a monitor checks each reset, start, done and reset-release event.
module tb_cpu_run_ctrl;

    localparam int unsigned PROG_W     = 2;
    localparam int unsigned CNT_W      = 16;
    localparam int unsigned TIMEOUT    = 16;
    localparam int unsigned RST_CYCLES = 2;

    localparam int K_RST   = 0;
    localparam int K_IDLE  = 1;
    localparam int K_START = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int kind;
        int prog;
        int cnt;
        int tmo;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Req = 1'b0;
    logic [PROG_W-1:0] ProgSel = '0;
    logic              Abort = 1'b0;
    logic              CpuAck = 1'b0;
    logic              Busy, Done, TimedOut, CpuReset, CpuStart;
    logic [CNT_W-1:0]  CycleCount;
    logic [PROG_W-1:0] CpuProgSel;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_run_ctrl #(
        .PROG_W(PROG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .ProgSel(ProgSel), .Abort(Abort),
        .Busy(Busy), .Done(Done), .TimedOut(TimedOut), .CycleCount(CycleCount),
        .CpuReset(CpuReset), .CpuStart(CpuStart), .CpuProgSel(CpuProgSel),
        .CpuAck(CpuAck)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    endtask

    task automatic push(input int kind, input int prog, input int cnt, input int tmo);
        exp_t e;
        e.kind = kind; e.prog = prog; e.cnt = cnt; e.tmo = tmo;
        q.push_back(e);
    endtask

    task automatic pop_for(input int kind, output exp_t e, output bit ok);
        e = '{kind: -1, prog: 0, cnt: 0, tmo: 0};
        if (q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            ok = 1'b0;
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: samples after each falling clock edge and on async reset assertion
    initial begin
        bit   prev_rst = 1'b1, prev_cres = 1'b0, prev_done = 1'b0;
        int   hold_len = 0;
        exp_t e;
        bit   ok;
        forever begin
            @(negedge Clk or negedge Reset);
            #1;
            if (prev_rst && !Reset) begin
                pop_for(K_RST, e, ok);
                if (ok) begin
                    chk("rst_cpu_reset", int'(CpuReset), 1);
                    chk("rst_cpu_start", int'(CpuStart), 0);
                    chk("rst_busy", int'(Busy), 0);
                    chk("rst_done", int'(Done), 0);
                    chk("rst_timed_out", int'(TimedOut), 0);
                    chk("rst_cycle_count", int'(CycleCount), 0);
                    chk("rst_prog_sel", int'(CpuProgSel), 0);
                end
                hold_len = 0;
            end else if (Reset) begin
                if (CpuReset) begin
                    hold_len++;
                end else if (prev_cres) begin
                    pop_for(K_IDLE, e, ok);
                    if (ok) begin
                        chk("hold_len", hold_len, int'(RST_CYCLES));
                        chk("idle_busy", int'(Busy), 0);
                        chk("idle_done", int'(Done), 0);
                        chk("idle_timed_out", int'(TimedOut), e.tmo);
                        chk("idle_cycle_count", int'(CycleCount), e.cnt);
                        chk("idle_prog_sel", int'(CpuProgSel), e.prog);
                    end
                    hold_len = 0;
                end
                if (CpuStart) begin
                    pop_for(K_START, e, ok);
                    if (ok) begin
                        chk("start_prog_sel", int'(CpuProgSel), e.prog);
                        chk("start_busy", int'(Busy), 1);
                        chk("start_done", int'(Done), 0);
                        chk("start_timed_out", int'(TimedOut), 0);
                        chk("start_cpu_reset", int'(CpuReset), 0);
                    end
                end
                if (Done && !prev_done) begin
                    pop_for(K_DONE, e, ok);
                    if (ok) begin
                        chk("done_cycle_count", int'(CycleCount), e.cnt);
                        chk("done_busy", int'(Busy), 0);
                        chk("done_timed_out", int'(TimedOut), 0);
                        chk("done_prog_sel", int'(CpuProgSel), e.prog);
                    end
                end
            end
            prev_rst  = Reset;
            prev_cres = CpuReset;
            prev_done = Done;
        end
    end

    // Issue Req for one cycle; returns positioned inside the first RUN cycle
    task automatic launch(input int prog);
        Req = 1'b1;
        ProgSel = PROG_W'(prog);
        @(posedge Clk); #1;
        Req = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic drive_ack(input bit v, input int n);
        repeat (n) begin
            CpuAck = v;
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        // Power-up reset and release
        push(K_RST, 0, 0, 0);
        push(K_IDLE, 0, 0, 0);
        #2 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (4) @(posedge Clk);
        #1;

        // Ack on 10th RUN cycle; Abort while in DONE is ignored
        push(K_START, 2, 0, 0);
        push(K_DONE, 2, 10, 0);
        launch(2);
        drive_ack(1'b0, 9);
        drive_ack(1'b1, 1);
        Abort = 1'b1;
        repeat (2) begin @(posedge Clk); #1; end
        Abort = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end

        // Sticky Ack from the previous run must be seen low first
        push(K_START, 1, 0, 0);
        push(K_DONE, 1, 5, 0);
        launch(1);
        drive_ack(1'b1, 3);
        drive_ack(1'b0, 1);
        drive_ack(1'b1, 1);
        repeat (2) begin @(posedge Clk); #1; end
        CpuAck = 1'b0;

        // Watchdog after TIMEOUT RUN cycles; CycleCount keeps 5
        push(K_START, 3, 0, 0);
        push(K_IDLE, 3, 5, 1);
        launch(3);
        drive_ack(1'b0, int'(TIMEOUT));
        repeat (4) begin @(posedge Clk); #1; end

        // Abort beats qualified Ack; Req in RUN and RST_HOLD ignored
        push(K_START, 0, 0, 0);
        push(K_IDLE, 0, 5, 0);
        launch(0);
        drive_ack(1'b0, 2);
        Req = 1'b1;
        ProgSel = 2'd3;
        @(posedge Clk); #1;
        Req = 1'b0;
        CpuAck = 1'b1;
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        CpuAck = 1'b0;
        Req = 1'b1;
        repeat (2) begin @(posedge Clk); #1; end
        Req = 1'b0;
        repeat (3) begin @(posedge Clk); #1; end

        // Asynchronous reset mid-RUN
        push(K_START, 2, 0, 0);
        push(K_RST, 0, 0, 0);
        push(K_IDLE, 0, 0, 0);
        launch(2);
        drive_ack(1'b0, 3);
        #1 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (6) begin @(posedge Clk); #1; end

        chk("events_outstanding", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got t=%0t expected finish earlier", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
